divider_multicycle: RTL and testbench



---
 rtl/divider_multicycle_if.sv | 26 ++
 rtl/divider_multicycle.sv | 73 +++++++
 tb/tb_divider_multicycle.sv | 113 +++++++++++
 3 files changed

// File: rtl/divider_multicycle_if.sv
// divider_multicycle_if: start/operand/result bundle for the divider (data_remainder only with DIVIDER_REMAINDER_EN)
interface divider_multicycle_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
`ifdef DIVIDER_REMAINDER_EN
  logic [31:0] data_remainder;
`endif
  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
`ifdef DIVIDER_REMAINDER_EN
    , input data_remainder
`endif
  );
  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
`ifdef DIVIDER_REMAINDER_EN
    , output data_remainder
`endif
  );
endinterface

// File: rtl/divider_multicycle.sv
// divider_multicycle: 32-step restoring signed divider; clock, reset (sync, active-high), bus (slave: ctrl_DIV start, operands in; data_result, data_exception, data_resultRDY and data_remainder when DIVIDER_REMAINDER_EN out)
module divider_multicycle (
  input logic clock,
  input logic reset,
  divider_multicycle_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] q, b_abs, r, result;
  logic [4:0] cnt;
  logic q_sign, r_sign, exc;
  logic [31:0] a_in, b_in, r_sub, r_step, q_step;
  logic [32:0] r_sh;
  logic fit, b_zero;
  assign a_in = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
  assign b_in = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;
  assign b_zero = bus.data_operandB == 32'd0;
  // r_sh is the 33-bit shifted partial remainder; after a restore it always fits in 32 bits
  assign r_sh = {r, q[31]};
  assign fit = r_sh >= {1'b0, b_abs};
  assign r_sub = r_sh[31:0] - b_abs;
  assign r_step = fit ? r_sub : r_sh[31:0];
  assign q_step = {q[30:0], fit};
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  // a start in any state (re)loads the operands, aborting a running division
  always_comb
    state_n = bus.ctrl_DIV ? (b_zero ? DONE : RUN) :
              state == RUN ? (cnt == 5'd31 ? DONE : RUN) : IDLE;
  always_comb
    bus.data_resultRDY = state == DONE;
`ifdef DIVIDER_REMAINDER_EN
  logic [31:0] rem;
  assign bus.data_remainder = rem;
  always_ff @(posedge clock)
    if (reset) rem <= '0;
    else if (bus.ctrl_DIV) begin
      if (b_zero) rem <= bus.data_operandA;
    end else if (state == RUN && cnt == 5'd31) rem <= r_sign ? -r_step : r_step;
`endif
  assign bus.data_result = result;
  assign bus.data_exception = exc;
  always_ff @(posedge clock)
    if (reset) begin
      q <= '0;
      b_abs <= '0;
      r <= '0;
      cnt <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      result <= '0;
      exc <= 1'b0;
    end else if (bus.ctrl_DIV) begin
      q <= a_in;
      b_abs <= b_in;
      r <= '0;
      cnt <= '0;
      q_sign <= bus.data_operandA[31] ^ bus.data_operandB[31];
      r_sign <= bus.data_operandA[31];
      if (b_zero) begin
        result <= '0;
        exc <= 1'b1;
      end
    end else if (state == RUN) begin
      q <= q_step;
      r <= r_step;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        result <= q_sign ? -q_step : q_step;
        exc <= 1'b0;
      end
    end
endmodule

// File: tb/tb_divider_multicycle.sv
// tb_divider_multicycle: scoreboard bench for divider_multicycle with directed vectors
module tb_divider_multicycle;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  divider_multicycle_if bus();
  divider_multicycle dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] q;
    logic [31:0] exc;
    logic [31:0] rem;
    int cyc;
    string name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0;
  int total = 0;
  int passed = 0;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask
  always @(negedge clock)
    if (bus.data_resultRDY !== 1'b0) begin
      if (sb.size() == 0) check("unexpected_ready", 32'(bus.data_resultRDY), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, bus.data_result, mon_e.q);
        check({mon_e.name, "_exception"}, 32'(bus.data_exception), mon_e.exc);
        check({mon_e.name, "_ready_cycle"}, 32'(cyc), 32'(mon_e.cyc));
`ifdef DIVIDER_REMAINDER_EN
        check({mon_e.name, "_remainder"}, bus.data_remainder, mon_e.rem);
`endif
      end
    end
  task automatic issue(input int a, input int b, input int q, input int exc, input int rem,
                       input int lat, input bit track, input string name);
    @(negedge clock);
    bus.ctrl_DIV = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    if (track) sb.push_back('{q, exc, rem, cyc + lat, name});
  endtask
  task automatic idle();
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) begin
      check("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask
  initial begin
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_result", bus.data_result, 32'd0);
    check("reset_exception", 32'(bus.data_exception), 32'd0);
    check("reset_ready", 32'(bus.data_resultRDY), 32'd0);
    repeat (5) @(negedge clock);
    issue(100, 7, 14, 0, 2, 33, 1, "pos_100_7");
    idle();
    wait_done();
    issue(-100, 7, -14, 0, -2, 33, 1, "neg_100_7");
    idle();
    wait_done();
    issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33, 1, "overflow");
    idle();
    wait_done();
    issue(-9, -2, 4, 0, -1, 33, 1, "neg9_neg2");
    idle();
    wait_done();
    issue(5, 0, 0, 1, 5, 1, 1, "div_zero");
    issue(6, 3, 2, 0, 0, 33, 1, "after_div_zero");
    idle();
    wait_done();
    issue(1000, 10, 100, 0, 0, 33, 0, "aborted");
    idle();
    repeat (8) @(negedge clock);
    issue(81, 9, 9, 0, 0, 33, 1, "restart_81_9");
    idle();
    wait_done();
    issue(50, 5, 10, 0, 0, 33, 0, "reset_victim");
    idle();
    repeat (13) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrun_reset_result", bus.data_result, 32'd0);
    check("midrun_reset_exception", 32'(bus.data_exception), 32'd0);
    check("midrun_reset_ready", 32'(bus.data_resultRDY), 32'd0);
`ifdef DIVIDER_REMAINDER_EN
    check("midrun_reset_remainder", bus.data_remainder, 32'd0);
`endif
    repeat (40) @(negedge clock);
    issue(50, 5, 10, 0, 0, 33, 1, "after_reset_50_5");
    idle();
    wait_done();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
